// File: rtl/mul_sequencer_pkg.sv
// rtl/mul_sequencer_pkg.sv - ALU control codes and multiply sequencer state encoding
package mul_sequencer_pkg;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_MUL = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - EX-stage multiply request/response signal bundle
interface mul_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic             stall_o;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] data_o;

   modport master (
      output valid_i, ALUCtrl_i, data1_i, data2_i,
      input  stall_o, busy_o, done_o, data_o
   );

   modport slave (
      input  valid_i, ALUCtrl_i, data1_i, data2_i,
      output stall_o, busy_o, done_o, data_o
   );
endinterface

// File: rtl/mul_seq_datapath.sv
// rtl/mul_seq_datapath.sv - shift-add registers; MUL_SEQUENCER_EARLY_EXIT_EN ends iteration once the multiplier empties
module mul_seq_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] mcand_in,
   input  logic [WIDTH-1:0] mplr_in,
   output logic [WIDTH-1:0] acc,
   output logic             last_step
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [CW-1:0]    count;

   always_ff @(posedge clk) begin
      if (clear) begin
         acc   <= '0;
         mcand <= '0;
         mplr  <= '0;
         count <= '0;
      end else if (load) begin
         acc   <= '0;
         mcand <= mcand_in;
         mplr  <= mplr_in;
         count <= '0;
      end else if (step) begin
         if (mplr[0]) begin
            acc <= acc + mcand;
         end
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         if (count != CW'(WIDTH)) begin
            count <= count + CW'(1);
         end
      end
   end

   // Evaluated during the current step: true when this step is the final one.
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
   assign last_step = (count == CW'(WIDTH - 1)) || (mplr[WIDTH-1:1] == '0);
`else
   assign last_step = (count == CW'(WIDTH - 1));
`endif

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle multiply controller stalling the EX stage until the product is ready
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   mul_sequencer_if.slave bus
);
   mul_state_t state;
   mul_state_t state_next;

   logic start;
   logic load;
   logic step;
   logic last_step;
   logic stall;
   logic busy;
   logic done;
   logic [WIDTH-1:0] acc;

   assign start = bus.valid_i && (bus.ALUCtrl_i == ALU_MUL);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      stall      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               stall      = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step  = 1'b1;
            stall = 1'b1;
            busy  = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         // Stall drops here so the pipeline retires the multiply this cycle.
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   mul_seq_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk       (clk_i),
      .clear     (rst_i),
      .load      (load),
      .step      (step),
      .mcand_in  (bus.data1_i),
      .mplr_in   (bus.data2_i),
      .acc       (acc),
      .last_step (last_step)
   );

   assign bus.stall_o = stall;
   assign bus.busy_o  = busy;
   assign bus.done_o  = done;
   assign bus.data_o  = acc;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - scoreboard bench for mul_sequencer against an arithmetic reference
module tb_mul_sequencer;
   import mul_sequencer_pkg::*;

   localparam int W = 32;
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] prod;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_sequencer_if #(.WIDTH(W)) bus ();

   mul_sequencer #(.WIDTH(W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return p[W-1:0];
   endfunction

   // Cycle (relative to the accept cycle) in which done is expected.
   function automatic int ref_lat(input logic [W-1:0] b);
      int k;
      k = 0;
      for (int i = 0; i < W; i++) if (b[i]) k = i;
      return EARLY ? k + 2 : W + 1;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && bus.done_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", bus.data_o, e.prod);
            check("done_cycle", W'(cyc), W'(e.cyc));
         end
      end
   end

   // Holds the operands on the bus for the whole stall and the DONE cycle, like a frozen EX stage.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int c0;
      int lat;
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = ALU_MUL;
      bus.data1_i   = a;
      bus.data2_i   = b;
      lat = ref_lat(b);
      c0  = cyc;
      sb.push_back('{ref_prod(a, b), c0 + lat});
      #1;
      check("stall_start", bus.stall_o, 1);
      check("busy_start", bus.busy_o, 0);
      for (int k = 1; k <= lat; k++) begin
         next();
         check("stall", bus.stall_o, (k < lat));
         check("busy", bus.busy_o, 1);
         if (k == 1) check("data_clear", bus.data_o, 0);
      end
   endtask

   task automatic bubble(input int n, input logic [W-1:0] held);
      for (int i = 0; i < n; i++) begin
         bus.valid_i   = 1'b0;
         bus.ALUCtrl_i = ALU_MUL;
         bus.data1_i   = $urandom;
         bus.data2_i   = $urandom;
         #1;
         check("idle_stall", bus.stall_o, 0);
         check("idle_busy", bus.busy_o, 0);
         check("idle_hold", bus.data_o, held);
         next();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   code;
      int           gap;

      rst = 1'b1;
      bus.valid_i   = 1'b0;
      bus.ALUCtrl_i = ALU_ADD;
      bus.data1_i   = '0;
      bus.data2_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_stall", bus.stall_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_data", bus.data_o, 0);
      next();

      run_mul(7, 6);
      next();
      bubble(3, 42);

      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      next();
      bubble(2, 1);

      for (int i = 0; i < 8; i++) begin
         bus.valid_i   = (i == 7) ? 1'b0 : 1'b1;
         code          = (i == 7) ? ALU_MUL : ((i < 4) ? 3'(i) : 3'(i + 1));
         bus.ALUCtrl_i = code;
         bus.data1_i   = $urandom;
         bus.data2_i   = $urandom;
         #1;
         check("nonmul_stall", bus.stall_o, 0);
         check("nonmul_busy", bus.busy_o, 0);
         check("nonmul_done", bus.done_o, 0);
         next();
      end

      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = ALU_MUL;
      bus.data1_i   = 3;
      bus.data2_i   = 4;
      for (int k = 0; k < 10; k++) next();
      rst = 1'b1;
      next();
      rst = 1'b0;
      bus.valid_i = 1'b0;
      #1;
      check("abort_busy", bus.busy_o, 0);
      check("abort_stall", bus.stall_o, 0);
      check("abort_data", bus.data_o, 0);
      next();
      run_mul(3, 4);
      next();
      bubble(1, 12);

      run_mul(2, 3);
      next();
      run_mul(5, 5);
      next();
      bubble(4, 25);

      run_mul(32'h1234, 5);
      next();
      bubble(1, 32'h5B04);
      run_mul(32'h1234, 0);
      next();
      bubble(1, 0);

      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case ($urandom_range(0, 2))
            0:       b = $urandom;
            1:       b = W'($urandom_range(0, 15));
            default: b = W'(1) << $urandom_range(0, W - 1);
         endcase
         run_mul(a, b);
         next();
         gap = $urandom_range(0, 2);
         if (gap > 0) bubble(gap, ref_prod(a, b));
      end
      bubble(3, ref_prod(a, b));

      check("sb_drain", W'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-add multiply controller that sits beside the EX-stage ALU.
- Detects a multiply op (ALU control code 3'd4) on a valid EX instruction.
- Stalls the pipeline while the operation runs.
- Iterates one multiplier bit per cycle.
- Presents the low WIDTH bits of the product with a one-cycle done strobe, then releases the stall.

## Interface
- WIDTH, 32, operand/result width; iteration count without early exit.
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  EX stage holds a real (non-bubble) instruction.
- ALUCtrl_i  in  3  ALU control code; 3'd4 = multiply, all others ignored.
- data1_i  in  WIDTH  multiplicand.
- data2_i  in  WIDTH  multiplier.
- stall_o  out  1  freeze PC/IF/ID/EX pipeline registers.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  one-cycle strobe; data_o valid.
- data_o  out  WIDTH  product mod 2^WIDTH.

## Operation
- Reset values: stall_o=0, busy_o=0, done_o=0, data_o=0.
- State after reset: IDLE; acc/mcand/mplr/count all 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start = valid_i && ALUCtrl_i==3'd4.
  - On start: latch mcand=data1_i, mplr=data2_i, acc=0, count=0; go to RUN.
  - stall_o is combinationally high in the start cycle.
- RUN, each cycle:
  - If mplr[0], acc += mcand (truncate to WIDTH).
  - mcand <<= 1; mplr >>= 1; count++.
  - After the step with count==WIDTH-1, go to DONE.
- DONE:
  - done_o=1, stall_o=0, data_o=acc.
  - Pipeline advances at the end of this cycle; next state IDLE.
  - The same instruction is never re-accepted.
- stall_o = (IDLE && start) || RUN.
- busy_o = RUN || DONE.
- data_o is driven by acc:
  - holds the last result until the next start;
  - clears to 0 in the cycle after a start.
- Arithmetic: low-half product only, so signed and unsigned results are identical; no overflow flag.
- Inputs are ignored in RUN/DONE.
- valid_i=0 with code 4 does not start.
- rst_i in any state: next cycle IDLE, all registers and outputs 0, stall_o dropped. The in-flight multiply is discarded.

## Timing
- Start accepted in cycle 0.
- RUN occupies cycles 1..WIDTH.
- DONE/done_o in cycle WIDTH+1.
- Stall high cycles 0..WIDTH (WIDTH+1 cycles).
- Back-to-back multiplies: the second is accepted in the cycle after DONE.
- No combinational path from data*_i to any output.

## Configuration
- Macro: MUL_SEQUENCER_EARLY_EXIT_EN.
- Defined:
  - RUN goes to DONE after any step whose shifted mplr is 0.
  - Zero or one multiplier: DONE in cycle 2.
  - Nonzero multiplier with MSB set bit k: DONE in cycle k+2.
  - count still saturates at WIDTH.
- Undefined: fixed WIDTH iterations as above.
- Result is identical either way.

## Structure
- Shared package/header holds:
  - ALU control code constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=3, ALU_MUL=4 (shared with ALU and ALU control).
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, mul_seq_datapath:
  - registers: acc, mcand, mplr, count;
  - controls: load/step/clear;
  - FSM and handshake stay in mul_sequencer.

## Test plan
- 7×6, macro off:
  - stall_o high cycles 0..32;
  - done_o in cycle 33 with data_o=42;
  - stall_o=0 in cycle 33.
- 0xFFFFFFFF×0xFFFFFFFF: data_o=0x00000001 at done_o.
- valid_i=1, ALUCtrl_i=3'd2: stall_o, busy_o, done_o stay 0; state remains IDLE.
- Reset during a multiply:
  - start 3×4, assert rst_i in cycle 10 → cycle 11: busy_o=0, stall_o=0, data_o=0;
  - then restart 3×4 → data_o=12 at done.
- Back-to-back 2×3 then 5×5: results 6 then 25; second start in the cycle after the first done_o; no duplicate done.
- Macro on:
  - 0x1234×5 → done_o in cycle 4, data_o=0x5B04;
  - 0x1234×0 → done_o in cycle 2, data_o=0.
